bomb_sprite_fetch: RTL and testbench

//  Upstream feeder for the bomb palette lookup: per VGA pixel, tests whether DrawX/DrawY lies inside the bomb sprite box.

---
 rtl/bomb_sprite_fetch.sv | 202 ++++++++++++++++++++
 tb/tb_bomb_sprite_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bomb_sprite_fetch.sv
// Bomb sprite fetch: per-pixel box test against the bomb's top-left corner,
// sprite ROM addressing, and the bomb lifecycle (hidden/live/flash/done).
// The palette index and opaque flag come out a fixed 3 cycles after the
// pixel coordinates, and out_valid travels with them.
module bomb_sprite_fetch #(
  parameter int          SPR_W        = 32,
  parameter int          SPR_H        = 32,
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  TRANSP_IDX   = 8'd0,
  parameter logic [7:0]  FLASH_IDX    = 8'd7,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vsync_pulse,
  input  logic              bomb_en,
  input  logic [9:0]        bomb_x,
  input  logic [9:0]        bomb_y,
  input  logic              sliced,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        index,
  output logic              pix_on,
  output logic              out_valid,
  output logic              bomb_gone
);

  // The flash counter needs at least two bits, because bit 1 selects the
  // flash colour versus the real sprite colour.
  localparam int FC_W = ($clog2(FLASH_FRAMES) < 2) ? 2 : $clog2(FLASH_FRAMES);
  localparam logic [FC_W-1:0] LP_FLAST = FC_W'(FLASH_FRAMES - 1);
  localparam logic signed [10:0] LP_SPR_W = 11'(SPR_W);
  localparam logic signed [10:0] LP_SPR_H = 11'(SPR_H);

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'd0,
    ST_LIVE   = 2'd1,
    ST_FLASH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Lifecycle and frame-stable shadow registers
  state_t              r_state;
  logic [FC_W-1:0]     r_fcnt;
  logic                r_pend;
  logic                r_gone;
  logic [9:0]          r_bx;
  logic [9:0]          r_by;

  // Pipeline registers
  logic [ADDR_W-1:0]   r_addr_p0;
  logic                r_hit_p0;
  logic                r_vld_p0;
  logic                r_hit_p1;
  logic                r_vld_p1;
  logic [7:0]          r_index_p2;
  logic                r_pix_on_p2;
  logic                r_vld_p2;

  // Combinational helpers
  logic signed [10:0]  w_dx;
  logic signed [10:0]  w_dy;
  logic                w_hit;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_visible;
  logic                w_flash_sub;
  logic                w_opaque;
  logic [7:0]          w_index;

  // Inside-box test on signed offsets; a box that runs past the right or
  // bottom screen edge simply clips, it never wraps back to column/row 0.
  function automatic logic in_box(input logic signed [10:0] dx,
                                  input logic signed [10:0] dy);
    return (dx >= 11'sd0) && (dx < LP_SPR_W) &&
           (dy >= 11'sd0) && (dy < LP_SPR_H);
  endfunction

  // Row-major sprite address; only meaningful when the pixel is in the box.
  function automatic logic [ADDR_W-1:0] spr_addr(input logic signed [10:0] dx,
                                                 input logic signed [10:0] dy);
    return ADDR_W'(dy[9:0]) * ADDR_W'(SPR_W) + ADDR_W'(dx[9:0]);
  endfunction

  // Palette index: 0 when the pixel is not drawn, the flash colour on the
  // flash half-cycles, otherwise the ROM word as stored.
  function automatic logic [7:0] sel_index(input logic       opaque,
                                           input logic       flash_sub,
                                           input logic [7:0] data);
    if (!opaque)
      return 8'd0;
    else if (flash_sub)
      return FLASH_IDX;
    else
      return data;
  endfunction

  // ---- stage A (pixel cycle N): box test against the shadow corner ----
  assign w_dx   = $signed({1'b0, DrawX}) - $signed({1'b0, r_bx});
  assign w_dy   = $signed({1'b0, DrawY}) - $signed({1'b0, r_by});
  assign w_hit  = in_box(w_dx, w_dy);
  assign w_addr = w_hit ? spr_addr(w_dx, w_dy) : '0;

  // ---- stage C (cycle N+2): ROM word is present, decide opacity ----
  assign w_visible   = (r_state == ST_LIVE) || (r_state == ST_FLASH);
  assign w_flash_sub = (r_state == ST_FLASH) && !r_fcnt[1];
  assign w_opaque    = r_hit_p1 && r_vld_p1 && (rom_data != TRANSP_IDX) && w_visible;
  assign w_index     = sel_index(w_opaque, w_flash_sub, rom_data);

  // Lifecycle FSM and shadow corner; everything moves on vsync except the
  // slice latch, which catches a blade hit at any point in a live frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_HIDDEN;
      r_fcnt  <= '0;
      r_pend  <= 1'b0;
      r_gone  <= 1'b0;
      r_bx    <= '0;
      r_by    <= '0;
    end else begin
      if (vsync_pulse) begin
        r_bx <= bomb_x;
        r_by <= bomb_y;
      end
      case (r_state)
        ST_HIDDEN: begin
          if (vsync_pulse && bomb_en)
            r_state <= ST_LIVE;
        end
        ST_LIVE: begin
          if (vsync_pulse) begin
            // A slice landing on the vsync cycle itself still counts.
            if (r_pend || sliced) begin
              r_state <= ST_FLASH;
              r_fcnt  <= '0;
              r_pend  <= 1'b0;
            end else if (!bomb_en) begin
              r_state <= ST_HIDDEN;
            end
          end else if (sliced) begin
            r_pend <= 1'b1;
          end
        end
        ST_FLASH: begin
          if (vsync_pulse) begin
            if (r_fcnt == LP_FLAST) begin
              r_state <= ST_DONE;
              r_gone  <= 1'b1;
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (vsync_pulse && !bomb_en) begin
            r_state <= ST_HIDDEN;
            r_gone  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_HIDDEN;
          r_gone  <= 1'b0;
        end
      endcase
    end
  end

  // Three-stage pixel pipeline; reset empties it so no stale pixel leaks out.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr_p0   <= '0;
      r_hit_p0    <= 1'b0;
      r_vld_p0    <= 1'b0;
      r_hit_p1    <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_index_p2  <= '0;
      r_pix_on_p2 <= 1'b0;
      r_vld_p2    <= 1'b0;
    end else begin
      // ---- A -> B: address issued to the ROM ----
      r_addr_p0   <= w_addr;
      r_hit_p0    <= w_hit;
      r_vld_p0    <= pix_valid;
      // ---- B -> C: wait out the ROM read latency ----
      r_hit_p1    <= r_hit_p0;
      r_vld_p1    <= r_vld_p0;
      // ---- C -> output: registered palette index and opaque flag ----
      r_index_p2  <= w_index;
      r_pix_on_p2 <= w_opaque;
      r_vld_p2    <= r_vld_p1;
    end
  end

  assign rom_addr  = r_addr_p0;
  assign index     = r_index_p2;
  assign pix_on    = r_pix_on_p2;
  assign out_valid = r_vld_p2;
  assign bomb_gone = r_gone;

endmodule

// File: tb/tb_bomb_sprite_fetch.sv
// Bench for bomb_sprite_fetch: random frames of pixels, bomb positions,
// slices and one mid-frame reset, checked against a frame-level model of
// the bomb lifecycle and the sprite box.
module tb_bomb_sprite_fetch;

  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              vsync_pulse = 1'b0;
  logic              bomb_en = 1'b0;
  logic [9:0]        bomb_x = '0;
  logic [9:0]        bomb_y = '0;
  logic              sliced = 1'b0;
  logic              pix_valid = 1'b0;
  logic [9:0]        DrawX = '0;
  logic [9:0]        DrawY = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        index;
  logic              pix_on;
  logic              out_valid;
  logic              bomb_gone;

  logic [7:0] rom [0:1023];

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM, one cycle of latency.
  always @(posedge Clk) rom_data <= rom[rom_addr];

  bomb_sprite_fetch #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W),
    .TRANSP_IDX(8'd0), .FLASH_IDX(8'd7), .FLASH_FRAMES(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .vsync_pulse(vsync_pulse), .bomb_en(bomb_en),
    .bomb_x(bomb_x), .bomb_y(bomb_y), .sliced(sliced), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
    .index(index), .pix_on(pix_on), .out_valid(out_valid), .bomb_gone(bomb_gone)
  );

  typedef struct packed {
    logic       v;
    logic       on;
    logic [7:0] idx;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] exp_addr;
  int                n_checks = 0;
  int                n_fail   = 0;

  // Model: bomb corner latched at frame start, and the bomb's life story.
  int m_bx, m_by;
  bit m_alive;     // on screen, not yet sliced
  bit m_pend;      // sliced during the current live frame
  int m_flash;     // flash frame number 0..7, -1 when not flashing
  bit m_gone;      // finished flashing, waiting for the spawn to drop

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bx = 0; m_by = 0;
    m_alive = 0; m_pend = 0; m_flash = -1; m_gone = 0;
  endtask

  // One clock: check what the DUT shows after the edge, then drive this
  // cycle's inputs and record what they must produce.
  task automatic cycle(input bit rst, input bit vs, input bit en,
                       input int bxi, input int byi, input bit sl,
                       input bit pv, input int x, input int y);
    exp_t       e;
    int         dx, dy, a;
    bit         hit, vis;
    logic [7:0] d;
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid", out_valid, e.v);
    check("pix_on",    pix_on,    e.on);
    check("index",     index,     e.idx);
    check("rom_addr",  rom_addr,  exp_addr);
    check("bomb_gone", bomb_gone, m_gone);

    Reset       = rst;
    vsync_pulse = vs;
    bomb_en     = en;
    bomb_x      = 10'(bxi);
    bomb_y      = 10'(byi);
    sliced      = sl;
    pix_valid   = pv;
    DrawX       = 10'(x);
    DrawY       = 10'(y);

    if (rst) begin
      model_reset();
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
      exp_addr = '0;
    end else begin
      dx  = (x & 1023) - m_bx;
      dy  = (y & 1023) - m_by;
      hit = (dx >= 0) && (dx < SPR_W) && (dy >= 0) && (dy < SPR_H);
      a   = hit ? dy * SPR_W + dx : 0;
      exp_addr = a[ADDR_W-1:0];
      vis = m_alive || (m_flash >= 0);
      d   = rom[a];
      e   = '0;
      if (pv) begin
        e.v = 1'b1;
        if (hit && vis && d != 8'd0) begin
          e.on  = 1'b1;
          e.idx = (m_flash >= 0 && (m_flash % 4) < 2) ? 8'd7 : d;
        end
      end
      exp_q.push_back(e);

      if (vs) begin
        if (m_alive) begin
          if (m_pend || sl) begin
            m_alive = 0; m_pend = 0; m_flash = 0;
          end else if (!en) begin
            m_alive = 0;
          end
        end else if (m_flash >= 0) begin
          if (m_flash == 7) begin
            m_flash = -1; m_gone = 1;
          end else begin
            m_flash++;
          end
        end else if (m_gone) begin
          if (!en) m_gone = 0;
        end else if (en) begin
          m_alive = 1;
        end
        m_bx = bxi; m_by = byi;
      end else if (sl && m_alive) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, $urandom_range(0, 1023), $urandom_range(0, 1023), 0, 0, 0, 0);
  endtask

  // One frame: blanking, vsync with the new corner, corner probes, then a
  // burst of random pixels with the bomb inputs wiggling mid-frame.
  task automatic frame(input bit en, input int bx, input int by,
                       input bit sl_at_vs, input bit do_rst);
    int offx[8] = '{0, 31, 32, -1, 1, 2, 0, 31};
    int offy[8] = '{0, 31, 31,  0, 0, 0, 31, 0};
    int x, y;
    bit pv, sl;
    idle();
    idle();
    cycle(0, 1, en, bx, by, sl_at_vs, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      cycle(0, 0, en, $urandom_range(0, 1023), $urandom_range(0, 1023), 0, 1,
            (bx + offx[k]) & 1023, (by + offy[k]) & 1023);
    for (int k = 0; k < 60; k++) begin
      pv = ($urandom_range(0, 9) < 8);
      sl = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
      end else begin
        x = (bx + $urandom_range(0, 39) - 4) & 1023;
        y = (by + $urandom_range(0, 39) - 4) & 1023;
      end
      cycle((do_rst && k == 30), 0, en, $urandom_range(0, 1023),
            $urandom_range(0, 1023), sl, pv, x, y);
    end
  endtask

  initial begin
    int bx, by;
    bit en, slv;
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    rom[0] = 8'h5A;
    rom[1] = 8'h00;
    rom[2] = 8'h07;

    model_reset();
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
    exp_addr = '0;

    repeat (3) cycle(1, 0, 0, 0, 0, 0, 1, 5, 5);
    repeat (3) idle();

    for (int f = 0; f < 45; f++) begin
      case (f % 5)
        0: begin bx = 1000; by = 1005; end
        1: begin bx = 100;  by = 50;   end
        default: begin bx = $urandom_range(0, 1000); by = $urandom_range(0, 1000); end
      endcase
      en  = (f < 13) ? 1'b1 : ($urandom_range(0, 4) != 0);
      slv = (f == 2) ? 1'b1 : ((f > 13) && ($urandom_range(0, 5) == 0));
      frame(en, bx, by, slv, (f == 25));
    end

    repeat (4) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
